// File: rtl/speed_pkg.sv
// speed_pkg: one-hot speed encodings, controller FSM states and the speed-to-period multiplier.
package speed_pkg;

    localparam logic [3:0] SPEED1 = 4'b0001;
    localparam logic [3:0] SPEED2 = 4'b0010;
    localparam logic [3:0] SPEED3 = 4'b0100;
    localparam logic [3:0] SPEED4 = 4'b1000;

    typedef enum logic [1:0] {STOP, LOAD, RUN} state_e;

    function automatic logic [3:0] speed_mult(input logic [3:0] s);
        return (s == SPEED1) ? 4'd1 : (s == SPEED2) ? 4'd2 : (s == SPEED3) ? 4'd4 : 4'd8;
    endfunction

endpackage

// File: rtl/speed_divider.sv
// speed_divider: period counter that emits a registered one-cycle tick when it wraps at period-1.
module speed_divider #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             run,
    input  logic [CNT_W-1:0] period,
    output logic             tick
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic             wrap;

    always_comb begin
        wrap   = cnt_q == period - 1'b1;
        cnt_d  = clear ? '0 : run ? (wrap ? '0 : cnt_q + 1'b1) : cnt_q;
        tick_d = run && wrap;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/speed_ctrl.sv
// speed_ctrl: one-hot speed register stepped by edge-detected shift requests, driving a tick divider.
// Define SPEED_CTRL_WRAP_EN to make shifts wrap around instead of saturating.
module speed_ctrl
    import speed_pkg::*;
#(
    parameter int BASE_PERIOD = 4,
    parameter int CNT_W       = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       shl_req,
    input  logic       shr_req,
    output logic [3:0] speed,
    output logic       tick,
    output logic       speed_changed
);

    state_e     state_q, state_d;
    logic [3:0] speed_q, speed_d;
    logic       shl_prev_q, shr_prev_q, changed_q;
    logic       shl_e, shr_e, chg;
    logic [3:0] faster, slower;

    always_comb begin
        shl_e   = shl_req & ~shl_prev_q;
        shr_e   = shr_req & ~shr_prev_q;
`ifdef SPEED_CTRL_WRAP_EN
        faster  = (speed_q == SPEED1) ? SPEED4 : speed_q >> 1;
        slower  = (speed_q == SPEED4) ? SPEED1 : speed_q << 1;
`else
        faster  = (speed_q == SPEED1) ? SPEED1 : speed_q >> 1;
        slower  = (speed_q == SPEED4) ? SPEED4 : speed_q << 1;
`endif
        // A corrupted register is forced back to SPEED4, which also counts as a change
        speed_d = !$onehot(speed_q) ? SPEED4 :
                  (shr_e && !shl_e) ? faster :
                  (shl_e && !shr_e) ? slower : speed_q;
        chg     = speed_d != speed_q;
        state_d = !enable ? STOP : (chg || state_q == STOP) ? LOAD : RUN;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= STOP;
            speed_q    <= SPEED4;
            shl_prev_q <= 1'b0;
            shr_prev_q <= 1'b0;
            changed_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            speed_q    <= speed_d;
            shl_prev_q <= shl_req;
            shr_prev_q <= shr_req;
            changed_q  <= chg;
        end
    end

    // Divider follows the next state so the first tick lands exactly P cycles after LOAD
    speed_divider #(.CNT_W(CNT_W)) u_div (
        .clk   (clk),
        .rst   (rst),
        .clear (state_d != RUN),
        .run   (state_d == RUN),
        .period(CNT_W'(BASE_PERIOD * int'(speed_mult(speed_q)))),
        .tick  (tick)
    );

    assign speed         = speed_q;
    assign speed_changed = changed_q;

endmodule

// File: tb/tb_speed_ctrl.sv
// tb_speed_ctrl: directed and randomized checks of speed_ctrl against a cycle-indexed behavioural model.
module tb_speed_ctrl;

`ifdef SPEED_CTRL_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       shl_req = 1'b0;
    logic       shr_req = 1'b0;
    logic [3:0] speed;
    logic       tick;
    logic       speed_changed;

    int         checks = 0;
    int         errors = 0;

    int         m_idx, m_load, cyc;
    bit         m_pl, m_pr, m_act;
    logic [3:0] exp_speed;
    logic       exp_tick, exp_chg;

    speed_ctrl #(.BASE_PERIOD(4), .CNT_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .shl_req      (shl_req),
        .shr_req      (shr_req),
        .speed        (speed),
        .tick         (tick),
        .speed_changed(speed_changed)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_idx = 3; m_pl = 0; m_pr = 0; m_act = 0; m_load = 0;
        exp_speed = 4'b1000; exp_tick = 0; exp_chg = 0;
    endtask

    // Speed index 0..3 = SPEED1..SPEED4; a tick is due every P cycles counted from the LOAD cycle
    task automatic step(input logic e, input logic l, input logic r);
        bit le, re;
        int ni;
        @(negedge clk);
        enable = e; shl_req = l; shr_req = r;
        @(posedge clk);
        cyc++;
        le = l && !m_pl; re = r && !m_pr; m_pl = l; m_pr = r;
        ni = m_idx;
        if (re && !le) ni = (m_idx > 0) ? m_idx - 1 : (WRAP ? 3 : 0);
        if (le && !re) ni = (m_idx < 3) ? m_idx + 1 : (WRAP ? 0 : 3);
        exp_chg = ni != m_idx;
        m_idx = ni;
        if (!e) m_act = 0;
        else if (exp_chg || !m_act) begin m_act = 1; m_load = cyc; end
        exp_speed = 4'(1 << m_idx);
        exp_tick = m_act && cyc > m_load && ((cyc - m_load) % (4 << m_idx)) == 0;
        #1;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1; enable = 0; shl_req = 0; shr_req = 0;
        @(negedge clk);
        rst = 0;
        model_reset();
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({speed, tick, speed_changed} !== 6'b1000_0_0) begin
            errors++;
            $display("FAIL reset got speed=%b tick=%b chg=%b exp 1000/0/0", speed, tick, speed_changed);
        end
        @(negedge clk);
        rst = 0;
        model_reset();
    endtask

    task automatic test_slowest();
        int nt = 0, nc = 0;
        repeat (70) begin
            step(1, 0, 0);
            checks++;
            if ({speed, tick, speed_changed} !== {exp_speed, exp_tick, exp_chg}) begin
                errors++;
                $display("FAIL slowest cyc=%0d got %b/%b/%b exp %b/%b/%b", cyc, speed, tick, speed_changed, exp_speed, exp_tick, exp_chg);
            end
            nt += int'(tick); nc += int'(speed_changed);
        end
        checks++;
        if (nt != 2 || nc != 0) begin
            errors++;
            $display("FAIL slowest_counts ticks=%0d chg=%0d exp 2/0", nt, nc);
        end
    endtask

    task automatic test_shr_pulse();
        int nt = 0, nc = 0;
        for (int i = 0; i < 43; i++) begin
            step(1, 0, i < 3);
            checks++;
            if ({speed, tick, speed_changed} !== {exp_speed, exp_tick, exp_chg}) begin
                errors++;
                $display("FAIL shr_pulse cyc=%0d got %b/%b/%b exp %b/%b/%b", cyc, speed, tick, speed_changed, exp_speed, exp_tick, exp_chg);
            end
            nt += int'(tick); nc += int'(speed_changed);
        end
        checks++;
        if (speed !== 4'b0100 || nt != 2 || nc != 1) begin
            errors++;
            $display("FAIL shr_pulse_summary speed=%b ticks=%0d chg=%0d exp 0100/2/1", speed, nt, nc);
        end
    endtask

    task automatic test_four_shr();
        logic [3:0] tab [4];
        logic       ctab [4];
        tab  = '{4'b0100, 4'b0010, 4'b0001, WRAP ? 4'b1000 : 4'b0001};
        ctab = '{1'b1, 1'b1, 1'b1, WRAP};
        reset_dut();
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 1);
            checks++;
            if (speed !== tab[i] || speed_changed !== ctab[i] || exp_speed !== tab[i]) begin
                errors++;
                $display("FAIL four_shr step=%0d got %b/%b exp %b/%b", i, speed, speed_changed, tab[i], ctab[i]);
            end
            repeat (2) begin
                step(1, 0, 0);
                checks++;
                if ({speed, tick, speed_changed} !== {exp_speed, exp_tick, exp_chg}) begin
                    errors++;
                    $display("FAIL four_shr cyc=%0d got %b/%b/%b exp %b/%b/%b", cyc, speed, tick, speed_changed, exp_speed, exp_tick, exp_chg);
                end
            end
        end
    endtask

    task automatic test_both();
        int nc = 0;
        reset_dut();
        for (int i = 0; i < 60; i++) begin
            step(1, i == 30, (i == 0) || (i == 2) || (i == 30));
            checks++;
            if ({speed, tick, speed_changed} !== {exp_speed, exp_tick, exp_chg}) begin
                errors++;
                $display("FAIL both cyc=%0d got %b/%b/%b exp %b/%b/%b", cyc, speed, tick, speed_changed, exp_speed, exp_tick, exp_chg);
            end
            if (i >= 30) nc += int'(speed_changed);
        end
        checks++;
        if (speed !== 4'b0010 || nc != 0) begin
            errors++;
            $display("FAIL both_summary speed=%b chg=%0d exp 0010/0", speed, nc);
        end
    endtask

    task automatic test_stop();
        int nt = 0, first = -1;
        step(1, 0, 1);
        repeat (6) step(1, 0, 0);
        for (int i = 0; i < 20; i++) begin
            step(0, i == 10, 0);
            checks++;
            if ({speed, tick, speed_changed} !== {exp_speed, exp_tick, exp_chg}) begin
                errors++;
                $display("FAIL stop cyc=%0d got %b/%b/%b exp %b/%b/%b", cyc, speed, tick, speed_changed, exp_speed, exp_tick, exp_chg);
            end
            nt += int'(tick);
        end
        checks++;
        if (speed !== 4'b0010 || nt != 0) begin
            errors++;
            $display("FAIL stop_summary speed=%b ticks=%0d exp 0010/0", speed, nt);
        end
        for (int i = 0; i < 20; i++) begin
            step(1, 0, 0);
            checks++;
            if ({speed, tick, speed_changed} !== {exp_speed, exp_tick, exp_chg}) begin
                errors++;
                $display("FAIL reenable cyc=%0d got %b/%b/%b exp %b/%b/%b", cyc, speed, tick, speed_changed, exp_speed, exp_tick, exp_chg);
            end
            if (tick && first < 0) first = i;
        end
        checks++;
        if (first != 8) begin
            errors++;
            $display("FAIL reenable_first_tick got %0d exp 8", first);
        end
    endtask

    task automatic test_async_reset();
        int nt = 0, n = 0;
        step(1, 0, 1);
        step(1, 0, 0);
        while (!tick && n < 12) begin step(1, 0, 0); n++; end
        checks++;
        if (tick !== 1'b1 || speed !== 4'b0001) begin
            errors++;
            $display("FAIL arst_setup tick=%b speed=%b exp 1/0001 within 12 cycles", tick, speed);
        end
        rst = 1;
        #1;
        checks++;
        if ({speed, tick, speed_changed} !== 6'b1000_0_0) begin
            errors++;
            $display("FAIL arst got %b/%b/%b exp 1000/0/0", speed, tick, speed_changed);
        end
        @(negedge clk);
        rst = 0; enable = 0; shl_req = 0; shr_req = 0;
        model_reset();
        repeat (70) begin
            step(1, 0, 0);
            checks++;
            if ({speed, tick, speed_changed} !== {exp_speed, exp_tick, exp_chg}) begin
                errors++;
                $display("FAIL arst_run cyc=%0d got %b/%b/%b exp %b/%b/%b", cyc, speed, tick, speed_changed, exp_speed, exp_tick, exp_chg);
            end
            nt += int'(tick);
        end
        checks++;
        if (nt != 2) begin
            errors++;
            $display("FAIL arst_ticks got %0d exp 2", nt);
        end
    endtask

    task automatic test_random();
        reset_dut();
        repeat (1500) begin
            step($urandom_range(0, 15) != 0, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
            checks++;
            if ({speed, tick, speed_changed} !== {exp_speed, exp_tick, exp_chg}) begin
                errors++;
                $display("FAIL random cyc=%0d got %b/%b/%b exp %b/%b/%b", cyc, speed, tick, speed_changed, exp_speed, exp_tick, exp_chg);
            end
        end
    endtask

    initial begin
        cyc = 0;
        model_reset();
        test_reset();
        test_slowest();
        test_shr_pulse();
        test_four_shr();
        test_both();
        test_stop();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/speed_ctrl.md
# speed_ctrl

Sequential controller that owns the current timer speed and turns it into a periodic tick. It holds the one-hot speed register and edge-detects left/right shift requests. Each request steps the speed one position, saturating at the ends. A divider produces one `tick` per speed-dependent period. The block sits between the button/request front-end and the timer core, which consumes `tick` and `speed`.

## Interface
Parameters:
- `BASE_PERIOD`, default 4: cycles between ticks at SPEED1 (fastest); must be ≥ 2.
- `CNT_W`, default 6: divider counter width; must hold 8*BASE_PERIOD-1.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `enable` in 1: run the divider; low stops ticking.
- `shl_req` in 1: left-shift request level (slower); already synchronous to `clk`.
- `shr_req` in 1: right-shift request level (faster); already synchronous to `clk`.
- `speed` out 4: current speed, one-hot; 0001 SPEED1 fastest … 1000 SPEED4 slowest.
- `tick` out 1: one-cycle pulse per period.
- `speed_changed` out 1: one-cycle pulse when `speed` takes a new value.

## Operation
- Reset values: `speed`=1000 (SPEED4), `tick`=0, `speed_changed`=0, counter=0, request history regs=0, state=STOP.
- Request edges: `shl_e` = `shl_req` & ~`shl_prev`; `shr_e` likewise. History regs update every cycle.
- Next-speed rule, applied at the edge where the request edge is seen:
  - Only `shr_e`: shift one position toward SPEED1.
  - Only `shl_e`: shift one position toward SPEED4.
  - Both or neither: no change.
  - SPEED1 with `shr_e`, or SPEED4 with `shl_e`: no change, and no `speed_changed`.
- Period P = BASE_PERIOD × {1, 2, 4, 8} for SPEED1…SPEED4.
- FSM states:
  - STOP: counter held at 0, no tick.
  - LOAD: one cycle; counter cleared, no tick.
  - RUN: counter increments; at P-1 it wraps to 0 and `tick` pulses.
- Transitions:
  - STOP→LOAD when `enable`=1.
  - RUN→LOAD on a speed change.
  - LOAD→RUN when `enable`=1.
  - Any state→STOP when `enable`=0.
  - `enable`=0 takes priority over a speed change. Speed changes are still accepted in STOP, but the state stays STOP.
- Non-one-hot `speed` is unreachable. Recovery is in hardware anyway: any illegal value loads SPEED4 on the next edge and pulses `speed_changed`.

## Timing
- All outputs are registered.
- Request latency:
  - A request edge sampled at clock edge k updates `speed` at edge k; `speed_changed`=1 during the cycle after edge k.
  - The FSM is in LOAD during that same cycle.
- A request held high produces exactly one step. Another step needs a release of at least one cycle, then a re-assert.
- Tick timing:
  - After LOAD, the first `tick` is high P cycles later.
  - In steady state, `tick` repeats every P cycles.
  - A speed change resets phase: no tick appears within P cycles of the new speed's LOAD cycle except the scheduled one.
- `enable` low at edge k: STOP from edge k; no `tick` in the following cycle.
- `rst` asserted mid-period: all outputs return to reset values immediately, without waiting for a clock edge. After release, the block waits in STOP until `enable`.

## Configuration
- `SPEED_CTRL_WRAP_EN` defined: shifts wrap around. `shr_e` at SPEED1 → SPEED4; `shl_e` at SPEED4 → SPEED1. Both pulse `speed_changed` and enter LOAD.
- Undefined (default): saturate at both ends as described under Operation.

## Structure
- Shared package `speed_pkg` holds:
  - constants SPEED1..SPEED4 (4-bit one-hot);
  - the FSM state typedef (STOP, LOAD, RUN);
  - a function mapping one-hot speed to the period multiplier.
- One sub-module, `speed_divider`:
  - contains the counter, the period compare and the `tick` register;
  - inputs: `clk`, `rst`, `clear`, `run`, `period`.
- FSM, edge detect and speed register stay in `speed_ctrl`.

## Test plan
All scenarios use BASE_PERIOD=4.
- Reset, then `enable`=1 held → `speed`=1000, LOAD one cycle, then `tick` every 32 cycles; `speed_changed` never pulses.
- One 3-cycle `shr_req` pulse while running → `speed`=0100 one cycle later, `speed_changed` one pulse, first tick 16 cycles after the LOAD cycle, then every 16.
- Four separate `shr_req` pulses from 1000 → 0100, 0010, 0001, then 0001 with no `speed_changed` on the fourth. With `SPEED_CTRL_WRAP_EN`, the fourth gives 1000 plus a pulse.
- `shl_req` and `shr_req` rising in the same cycle at 0010 → `speed` stays 0010, no pulse, tick phase undisturbed (every 8).
- `enable` low for 20 cycles at 0001 → no ticks. A `shl_req` during STOP gives 0010 and a pulse. Re-enable → first tick 8 cycles after LOAD.
- `rst` pulsed mid-period at 0001 → `tick`=0 and `speed`=1000 asynchronously; after release with `enable`=1, ticks every 32.
